// File: rtl/rbm_input_loader_pkg.sv
// Shared configuration for the RBM input loader.
// Holds the loader FSM encoding, the length of the restart pulse sent to the
// RBM core, and the helper that locates a pixel inside a packed frame word.
package rbm_input_loader_pkg;

    // Loader controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,   // nothing presented, waiting for a full bank
        ST_PRESENT = 2'd1,   // a full frame is held stable for the RBM core
        ST_RESTART = 2'd2    // rbm_reset pulse after the core finished a frame
    } loader_state_t;

    // Number of cycles rbm_reset stays high after each finished frame
    localparam int RESTART_CYCLES = 2;
    localparam int RESTART_CNT_W  = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    // Ping-pong: one bank presented while the other fills
    localparam int NUM_BANKS = 2;

    // Port packing: pixel idx occupies bits [(idx+1)*width-1 : idx*width]
    function automatic int pixel_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rbm_frame_bank.sv
// One frame buffer of input_dim pixels, bitlength bits each.
// Words are written sequentially starting at index 0; the bank tracks its own
// write index and reports, for the word being written, whether it completes a
// well-framed frame or breaks framing. Either outcome rewinds the index to 0.
//
// Ports:
//   clock, reset   - clock, asynchronous active-low reset
//   wr_en          - write wr_data at the current write index
//   wr_data        - pixel word
//   wr_last        - upstream end-of-frame marker for this word
//   frame_done     - (comb) this write is the last pixel and wr_last is set
//   frame_err      - (comb) wr_last and end-of-frame position disagree
//   frame          - packed contents, pixel i at [(i+1)*bitlength-1 : i*bitlength]
module rbm_frame_bank
    import rbm_input_loader_pkg::*;
#(
    parameter int input_dim = 15,
    parameter int bitlength = 12
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [bitlength-1:0]           wr_data,
    input  logic                           wr_last,
    output logic                           frame_done,
    output logic                           frame_err,
    output logic [input_dim*bitlength-1:0] frame
);

    localparam int IDX_W = (input_dim > 1) ? $clog2(input_dim) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(input_dim - 1);

    logic [IDX_W-1:0] wr_idx_reg;
    logic [IDX_W-1:0] wr_idx_next;
    logic             at_end;

    assign at_end = (wr_idx_reg == LAST_IDX);

    // A good frame ends exactly when the last slot is written with wr_last.
    // Any disagreement between position and marker is a framing error.
    assign frame_done = wr_en && at_end && wr_last;
    assign frame_err  = wr_en && (at_end ^ wr_last);

    always_comb begin
        wr_idx_next = wr_idx_reg + IDX_W'(1);
        if (at_end || wr_last) begin
            wr_idx_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_idx_reg <= '0;
        end else if (wr_en) begin
            wr_idx_reg <= wr_idx_next;
        end
    end

    for (genvar gi = 0; gi < input_dim; gi++) begin : g_pixel
        logic [bitlength-1:0] pixel_reg;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                pixel_reg <= '0;
            end else if (wr_en && (wr_idx_reg == IDX_W'(gi))) begin
                pixel_reg <= wr_data;
            end
        end

        assign frame[pixel_lsb(gi, bitlength) +: bitlength] = pixel_reg;
    end

endmodule

// File: rtl/rbm_input_loader.sv
// Streams pixel words into ping-pong frame banks and presents complete frames
// to the RBM core (Main). While one bank is presented the other keeps filling.
// When Main raises finish, the presented bank is released, rbm_reset pulses for
// RESTART_CYCLES cycles, and the other bank is presented if it is already full.
//
// Ports:
//   clock, reset   - clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready - upstream pixel stream handshake
//   finish         - level from Main; its rising edge ends a presentation
//   rbm_reset      - restart pulse to Main
//   data_valid     - InputDataPort holds a complete frame
//   InputDataPort  - packed presented frame
//   frame_err      - one-cycle pulse on a framing error
module rbm_input_loader
    import rbm_input_loader_pkg::*;
#(
    parameter int input_dim = 15,
    parameter int bitlength = 12
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [bitlength-1:0]           in_data,
    input  logic                           in_last,
    output logic                           in_ready,
    input  logic                           finish,
    output logic                           rbm_reset,
    output logic                           data_valid,
    output logic [input_dim*bitlength-1:0] InputDataPort,
    output logic                           frame_err
);

    localparam int FRAME_W = input_dim * bitlength;

    loader_state_t            state_reg, state_next;
    logic [RESTART_CNT_W-1:0] restart_cnt_reg, restart_cnt_next;
    logic [NUM_BANKS-1:0]     bank_full_reg, bank_full_next;
    logic                     fill_sel_reg, fill_sel_next;
    logic                     pres_sel_reg, pres_sel_next;
    logic                     finish_reg;
    logic                     frame_err_reg;

    logic                     accept;
    logic                     finish_rise;
    logic                     free_bank;
    logic                     fill_other;
    logic [NUM_BANKS-1:0]     bank_wr_en;
    logic [NUM_BANKS-1:0]     bank_done;
    logic [NUM_BANKS-1:0]     bank_err;
    logic [FRAME_W-1:0]       bank_frame [NUM_BANKS];

    assign in_ready    = ~bank_full_reg[fill_sel_reg];
    assign accept      = in_valid && in_ready;
    assign finish_rise = finish && !finish_reg;
    assign fill_other  = ~fill_sel_reg;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        assign bank_wr_en[gi] = accept && (fill_sel_reg == 1'(gi));

        rbm_frame_bank #(
            .input_dim (input_dim),
            .bitlength (bitlength)
        ) u_bank (
            .clock      (clock),
            .reset      (reset),
            .wr_en      (bank_wr_en[gi]),
            .wr_data    (in_data),
            .wr_last    (in_last),
            .frame_done (bank_done[gi]),
            .frame_err  (bank_err[gi]),
            .frame      (bank_frame[gi])
        );
    end

    // Bank occupancy. A release and a completion in the same cycle both land:
    // they always target different banks (presented vs. filling).
    // Filling moves to the other bank only once it is empty, so the filling
    // bank never aliases the presented one.
    always_comb begin
        bank_full_next = bank_full_reg;
        if (free_bank) begin
            bank_full_next[pres_sel_reg] = 1'b0;
        end
        bank_full_next = bank_full_next | bank_done;

        fill_sel_next = fill_sel_reg;
        if (bank_full_next[fill_sel_reg] && !bank_full_next[fill_other]) begin
            fill_sel_next = fill_other;
        end
    end

    // Presentation controller
    always_comb begin
        state_next       = state_reg;
        restart_cnt_next = restart_cnt_reg;
        pres_sel_next    = pres_sel_reg;
        free_bank        = 1'b0;
        data_valid       = 1'b0;
        rbm_reset        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|bank_full_reg) begin
                    pres_sel_next = bank_full_reg[0] ? 1'b0 : 1'b1;
                    state_next    = ST_PRESENT;
                end
            end

            ST_PRESENT: begin
                data_valid = 1'b1;
                // finish already high on entry is not a new completion
                if (finish_rise) begin
                    free_bank        = 1'b1;
                    restart_cnt_next = '0;
                    state_next       = ST_RESTART;
                end
            end

            ST_RESTART: begin
                rbm_reset = 1'b1;
                if (restart_cnt_reg == RESTART_CNT_W'(RESTART_CYCLES - 1)) begin
                    if (bank_full_reg[~pres_sel_reg]) begin
                        pres_sel_next = ~pres_sel_reg;
                        state_next    = ST_PRESENT;
                    end else begin
                        state_next    = ST_IDLE;
                    end
                end else begin
                    restart_cnt_next = restart_cnt_reg + RESTART_CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            restart_cnt_reg <= '0;
            bank_full_reg   <= '0;
            fill_sel_reg    <= 1'b0;
            pres_sel_reg    <= 1'b0;
            finish_reg      <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            restart_cnt_reg <= restart_cnt_next;
            bank_full_reg   <= bank_full_next;
            fill_sel_reg    <= fill_sel_next;
            pres_sel_reg    <= pres_sel_next;
            finish_reg      <= finish;
            frame_err_reg   <= |bank_err;
        end
    end

    assign frame_err     = frame_err_reg;
    assign InputDataPort = bank_frame[pres_sel_reg];

endmodule

// File: tb/tb_rbm_input_loader.sv
// Bench for rbm_input_loader: directed scenarios followed by random streaming,
// all checked every cycle against a frame-queue reference model.
module tb_rbm_input_loader;

    localparam int N  = 15;
    localparam int W  = 12;
    localparam int DW = N * W;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          finish = 1'b0;
    logic          in_ready;
    logic          rbm_reset;
    logic          data_valid;
    logic [DW-1:0] InputDataPort;
    logic          frame_err;

    always #5 clock = ~clock;

    rbm_input_loader #(
        .input_dim (N),
        .bitlength (W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .finish        (finish),
        .rbm_reset     (rbm_reset),
        .data_valid    (data_valid),
        .InputDataPort (InputDataPort),
        .frame_err     (frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_frames = 0;

    // Reference model: frames held by the loader form a FIFO of at most two;
    // the head is what Main sees while presenting.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_part;
    int            m_idx;
    int            m_mode;      // 0 idle, 1 presenting, 2 restarting
    int            m_rleft;
    logic          m_prev_fin;
    logic          m_err;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_part     = '0;
        m_idx      = 0;
        m_mode     = 0;
        m_rleft    = 0;
        m_prev_fin = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic compare_outputs();
        check("in_ready",   in_ready,   m_q.size() < 2);
        check("data_valid", data_valid, m_mode == 1);
        check("rbm_reset",  rbm_reset,  m_mode == 2);
        check("frame_err",  frame_err,  m_err);
        if (m_mode == 1) begin
            check("frame", InputDataPort, m_q[0]);
        end
    endtask

    // Advance the model across one rising edge given this cycle's inputs.
    task automatic model_step(input logic v, input logic [W-1:0] d, input logic l, input logic f);
        logic acc;
        acc = v && (m_q.size() < 2);
        case (m_mode)
            0: if (m_q.size() > 0) m_mode = 1;
            1: if (f && !m_prev_fin) begin
                   void'(m_q.pop_front());
                   m_mode  = 2;
                   m_rleft = 2;
               end
            default: begin
                m_rleft--;
                if (m_rleft == 0) m_mode = (m_q.size() > 0) ? 1 : 0;
            end
        endcase
        m_err = 1'b0;
        if (acc) begin
            m_part[m_idx*W +: W] = d;
            if (m_idx == N-1 && l) begin
                m_q.push_back(m_part);
                n_frames++;
                $display("frame %0d accepted: pixel0=%h pixel14=%h", n_frames, m_part[W-1:0], m_part[DW-1 -: W]);
                m_idx = 0;
            end else if (m_idx == N-1 || l) begin
                m_err = 1'b1;
                $display("framing error at index %0d (last=%0b)", m_idx, l);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        m_prev_fin = f;
    endtask

    // Called at a falling edge: check outputs, drive inputs, step model.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic f);
        compare_outputs();
        in_valid = v;
        in_data  = d;
        in_last  = l;
        finish   = f;
        model_step(v, d, l, f);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic f);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, f);
    endtask

    initial begin
        logic fin_lvl;
        logic lst;
        logic [W-1:0] pix;

        model_reset();
        repeat (3) @(negedge clock);
        check("rst_data_valid", data_valid, 0);
        check("rst_rbm_reset",  rbm_reset,  0);
        check("rst_frame_err",  frame_err,  0);
        check("rst_port",       InputDataPort, 0);
        reset = 1'b1;

        // Frame A = 1..15
        for (int i = 1; i <= 15; i++) cycle(1'b1, W'(i), i == 15, 1'b0);
        idle(1, 1'b0);
        check("a_valid",   data_valid, 1);
        pix = InputDataPort[W-1:0];
        check("a_pixel0",  pix, 12'h001);
        pix = InputDataPort[DW-1 -: W];
        check("a_pixel14", pix, 12'h00F);

        // Frame B = 16..30 fills the second bank
        for (int i = 16; i <= 30; i++) cycle(1'b1, W'(i), i == 30, 1'b0);
        idle(1, 1'b0);
        check("b_ready_low", in_ready, 0);
        idle(3, 1'b1);
        check("b_valid",  data_valid, 1);
        pix = InputDataPort[W-1:0];
        check("b_pixel0", pix, 12'h010);
        idle(3, 1'b1);      // still held high: no second restart
        check("held_fin_valid", data_valid, 1);
        idle(2, 1'b0);
        idle(4, 1'b1);
        idle(2, 1'b0);

        // Early in_last on the 7th word
        for (int j = 0; j < 7; j++) cycle(1'b1, W'(100 + j), j == 6, 1'b0);
        check("early_last_err", frame_err, 1);
        idle(1, 1'b0);
        check("early_last_no_valid", data_valid, 0);
        for (int i = 0; i < 15; i++) cycle(1'b1, W'($urandom), i == 14, 1'b0);
        idle(2, 1'b0);
        check("clean_after_err", data_valid, 1);
        idle(1, 1'b1);
        idle(4, 1'b0);

        // Missing in_last: 16th word starts a new frame
        for (int j = 0; j < 16; j++) begin
            cycle(1'b1, W'(200 + j), 1'b0, 1'b0);
            if (j == 14) check("missing_last_err", frame_err, 1);
        end
        for (int j = 0; j < 14; j++) cycle(1'b1, W'(216 + j), j == 13, 1'b0);
        idle(2, 1'b0);
        check("restart_frame_valid", data_valid, 1);
        pix = InputDataPort[W-1:0];
        check("restart_frame_pix0", pix, 12'h0D7);

        // Second bank fills, then reset during presentation
        for (int i = 0; i < 15; i++) cycle(1'b1, W'(300 + i), i == 14, 1'b0);
        compare_outputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid_rst_valid",  data_valid, 0);
        check("mid_rst_rbmrst", rbm_reset,  0);
        check("mid_rst_port",   InputDataPort, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1);
        @(negedge clock);
        idle(3, 1'b0);

        // Random streaming with occasional framing faults and finish toggles
        fin_lvl = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) fin_lvl = ~fin_lvl;
            lst = (m_idx == N-1);
            if ($urandom_range(0, 24) == 0) lst = ~lst;
            cycle($urandom_range(0, 9) < 7, W'($urandom), lst, fin_lvl);
        end
        idle(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
